// File: rtl/sms_card_tal.sv
// IBM 1620 SMS "TAL" one-shot: an edge on b, gated by c, yields a PULSE_CYCLES-wide pulse on d.
// b is caught asynchronously, synchronized to x, and the FSM is non-retriggerable.
`timescale 1ns/100ps

module sms_card_tal #(
    parameter int unsigned PULSE_CYCLES    = 8,
    parameter int unsigned RECOVERY_CYCLES = 2
) (
    input  logic x,
    input  logic rst_n,
    input  logic b,
    input  logic c,
    output logic d
);

    localparam int unsigned MaxCycles = (PULSE_CYCLES > RECOVERY_CYCLES) ?
                                        PULSE_CYCLES : RECOVERY_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] PulseLoad   = CntW'(PULSE_CYCLES - 1);
    localparam logic [CntW-1:0] RecoverLoad = (RECOVERY_CYCLES > 0) ?
                                              CntW'(RECOVERY_CYCLES - 1) : '0;

    typedef enum logic [1:0] {StIdle, StPulse, StRecover} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            cap, s1, s2, s3;
    logic            cap_clr;
    logic            trig;

    // Pulse catcher: latches any b edge, however narrow; released once s2 acknowledges it.
    assign cap_clr = ~rst_n | s2;

    always_ff @(posedge b or posedge cap_clr) begin
        if (cap_clr) cap <= 1'b0;
        else         cap <= 1'b1;
    end

    always_ff @(posedge x or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= cap;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign trig = s2 & ~s3;

    always_ff @(posedge x or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            d       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (trig && c) begin
                        state_q <= StPulse;
                        cnt_q   <= PulseLoad;
                        d       <= 1'b1;
                    end
                end
                StPulse: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        d <= 1'b0;
                        if (RECOVERY_CYCLES == 0) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StRecover;
                            cnt_q   <= RecoverLoad;
                        end
                    end
                end
                StRecover: begin
                    // Triggers seen here, including on the IDLE-entry edge, are dropped.
                    if (cnt_q != '0) cnt_q   <= cnt_q - 1'b1;
                    else             state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    d       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sms_card_tal.sv
// Self-checking bench for sms_card_tal: randomized and directed b/c stimulus against an
// edge-indexed model (request lands 3 x edges after a b rise; busy window P+R+1 edges).
`timescale 1ns/100ps

module tb_sms_card_tal;

    localparam int P = 8;
    localparam int R = 2;

    logic x     = 1'b0;
    logic rst_n = 1'b0;
    logic b     = 1'b0;
    logic c     = 1'b0;
    logic d;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: edges are numbered from 1 at each rising x.
    int   ecnt    = 0;
    int   req_q[$];
    int   start_e = -1000;
    int   free_e  = 0;
    logic exp_d   = 1'b0;

    sms_card_tal #(
        .PULSE_CYCLES    (P),
        .RECOVERY_CYCLES (R)
    ) dut (
        .x     (x),
        .rst_n (rst_n),
        .b     (b),
        .c     (c),
        .d     (d)
    );

    always #1 x = ~x;

    always @(negedge rst_n) begin
        req_q.delete();
        start_e = -1000;
        free_e  = 0;
        exp_d   = 1'b0;
    end

    always @(posedge x) begin
        ecnt++;
        if (!rst_n) begin
            req_q.delete();
            start_e = -1000;
            free_e  = 0;
        end else begin
            while (req_q.size() > 0 && req_q[0] < ecnt) void'(req_q.pop_front());
            if (req_q.size() > 0 && req_q[0] == ecnt) begin
                void'(req_q.pop_front());
                if (ecnt >= free_e && c) begin
                    start_e = ecnt;
                    free_e  = ecnt + P + R + 1;
                end
            end
        end
        exp_d = rst_n && (ecnt >= start_e) && (ecnt < start_e + P);
    end

    // Called just after a falling x: b rises mid-cycle, request reaches the FSM 3 edges later.
    task automatic b_rise();
        #0.5;
        b = 1'b1;
        req_q.push_back(ecnt + 3);
    endtask

    task automatic b_pulse(input realtime w);
        b_rise();
        #(w);
        b = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        c     = 1'b1;
        b     = 1'b0;
        repeat (3) @(negedge x);
        n_chk++;
        if (d !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: d=%b expected=0", d);
        end
        #0.5 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge x);
            n_chk++;
            if (d !== exp_d || d !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle cyc %0d: d=%b expected=0", i, d);
            end
        end
    endtask

    task automatic test_basic();
        int r0;
        int first;
        int high;
        c = 1'b1;
        @(negedge x);
        r0    = ecnt;
        first = -1;
        high  = 0;
        b_pulse(1.0);
        for (int i = 0; i < 16; i++) begin
            @(negedge x);
            n_chk++;
            if (d !== exp_d) begin
                n_err++;
                $display("FAIL basic cyc %0d: d=%b expected=%b", i, d, exp_d);
            end
            if (d === 1'b1) begin
                high++;
                if (first < 0) first = ecnt - r0;
            end
        end
        n_chk++;
        if (high != P) begin
            n_err++;
            $display("FAIL basic_width: high=%0d expected=%0d", high, P);
        end
        n_chk++;
        if (first != 3) begin
            n_err++;
            $display("FAIL basic_latency: edge=%0d expected=3", first);
        end
    endtask

    task automatic test_gate();
        int high = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge x);
            n_chk++;
            if (d !== exp_d) begin
                n_err++;
                $display("FAIL gate cyc %0d: d=%b expected=%b", i, d, exp_d);
            end
            if (d === 1'b1) high++;
            if (i == 0) begin
                c = 1'b0;
                b_pulse(1.0);
            end
            if (i == 16) begin
                c = 1'b1;
                b_pulse(1.0);
            end
        end
        n_chk++;
        if (high != P) begin
            n_err++;
            $display("FAIL gate_width: high=%0d expected=%0d", high, P);
        end
    endtask

    // Pulses at i=4 (lands in PULSE) and i=10 (lands on the IDLE-entry edge) are dropped.
    task automatic test_retrigger();
        int high = 0;
        c = 1'b1;
        for (int i = 0; i < 44; i++) begin
            @(negedge x);
            n_chk++;
            if (d !== exp_d) begin
                n_err++;
                $display("FAIL retrig cyc %0d: d=%b expected=%b", i, d, exp_d);
            end
            if (d === 1'b1) high++;
            if (i == 0 || i == 4 || i == 10 || i == 20) b_pulse(1.0);
        end
        n_chk++;
        if (high != 2 * P) begin
            n_err++;
            $display("FAIL retrig_width: high=%0d expected=%0d", high, 2 * P);
        end
    endtask

    task automatic test_held();
        int high = 0;
        c = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge x);
            n_chk++;
            if (d !== exp_d) begin
                n_err++;
                $display("FAIL held cyc %0d: d=%b expected=%b", i, d, exp_d);
            end
            if (d === 1'b1) high++;
            if (i == 0)  b_rise();
            if (i == 30) b = 1'b0;
        end
        n_chk++;
        if (high != P) begin
            n_err++;
            $display("FAIL held_width: high=%0d expected=%0d", high, P);
        end
    endtask

    task automatic test_reset_mid();
        c = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge x);
            n_chk++;
            if (d !== exp_d) begin
                n_err++;
                $display("FAIL rstmid cyc %0d: d=%b expected=%b", i, d, exp_d);
            end
            if (i == 0 || i == 26) b_pulse(1.0);
            if (i == 6) begin
                n_chk++;
                if (d !== 1'b1) begin
                    n_err++;
                    $display("FAIL rstmid_pre: d=%b expected=1", d);
                end
                #0.5 rst_n = 1'b0;
                #0.2;
                n_chk++;
                if (d !== 1'b0) begin
                    n_err++;
                    $display("FAIL rstmid_async: d=%b expected=0", d);
                end
                @(negedge x);
                #0.5 rst_n = 1'b1;
            end
        end
    endtask

    task automatic test_random();
        int since = 10;
        for (int i = 0; i < 420; i++) begin
            @(negedge x);
            n_chk++;
            if (d !== exp_d) begin
                n_err++;
                $display("FAIL random cyc %0d: d=%b expected=%b c=%b", i, d, exp_d, c);
            end
            if ($urandom_range(0, 7) == 0) c = 1'($urandom_range(0, 1));
            since++;
            if (i < 400 && since >= 4 && $urandom_range(0, 4) == 0) begin
                since = 0;
                b_pulse($urandom_range(1, 10) / 10.0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gate();
        test_retrigger();
        test_held();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
